div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div.sv
// Multi-cycle restoring divider for the EX stage: 32-bit signed/unsigned operands,
// result packed as {remainder, quotient} after 32 shift-subtract iterations.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t      state_r;
   logic [5:0]  cnt_r;
   logic [31:0] dvd_r;     // dividend bits shift out the top, quotient bits shift in the bottom
   logic [31:0] dvs_r;
   logic [31:0] rem_r;
   logic        neg1_r;
   logic        neg2_r;

   logic [31:0] abs1_s;
   logic [31:0] abs2_s;
   logic [32:0] partial_s;
   logic [32:0] diff_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;

   // Operand magnitudes, one restoring step, and final sign fixup
   always_comb begin
      abs1_s    = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
      abs2_s    = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
      partial_s = {rem_r, dvd_r[31]};
      diff_s    = partial_s - {1'b0, dvs_r};
      quo_fix_s = (neg1_r ^ neg2_r) ? (32'd0 - dvd_r) : dvd_r;
      rem_fix_s = neg1_r ? (32'd0 - rem_r) : rem_r;
   end

   // Divider control FSM with registered result and ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= FREE;
         cnt_r    <= 6'd0;
         dvd_r    <= 32'd0;
         dvs_r    <= 32'd0;
         rem_r    <= 32'd0;
         neg1_r   <= 1'b0;
         neg2_r   <= 1'b0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         case (state_r)
            FREE: begin
               result_o <= 64'd0;
               ready_o  <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state_r <= BYZERO;
                  end else begin
                     state_r <= ON;
                     cnt_r   <= 6'd0;
                     dvd_r   <= abs1_s;
                     dvs_r   <= abs2_s;
                     rem_r   <= 32'd0;
                     neg1_r  <= signed_div_i & opdata1_i[31];
                     neg2_r  <= signed_div_i & opdata2_i[31];
                  end
               end else begin
                  state_r <= FREE;
               end
            end
            BYZERO: begin
               state_r  <= END;
               result_o <= 64'd0;
               ready_o  <= 1'b1;
            end
            ON: begin
               if (annul_i) begin
                  state_r  <= FREE;
                  cnt_r    <= 6'd0;
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
               end else if (cnt_r != 6'd32) begin
                  // diff_s[32] set means the trial subtraction went negative: restore
                  if (diff_s[32]) begin
                     rem_r <= {rem_r[30:0], dvd_r[31]};
                  end else begin
                     rem_r <= diff_s[31:0];
                  end
                  dvd_r <= {dvd_r[30:0], ~diff_s[32]};
                  cnt_r <= cnt_r + 6'd1;
               end else begin
                  state_r  <= END;
                  result_o <= {rem_fix_s, quo_fix_s};
                  ready_o  <= 1'b1;
               end
            end
            END: begin
               if (!start_i) begin
                  state_r  <= FREE;
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
               end else begin
                  state_r <= END;
               end
            end
            default: begin
               state_r  <= FREE;
               cnt_r    <= 6'd0;
               result_o <= 64'd0;
               ready_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
